// File: rtl/pc_seq.sv
// Program-counter sequencer: boot/run/halt fetch qualification, optional branch
// delay slot with a pending-target register, and COP0 redirect with EPC/BD capture.
//
// state | meaning
// BOOT  | first cycle out of reset; PC holds, no fetch
// RUN   | fetching; PC advances whenever the pipeline is not stalled
// HALT  | no fetch, PC frozen; left only by a COP0 redirect
module pc_seq #(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter bit                DELAY_SLOT = 1'b0
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              stall,
  input  logic              halt_req,
  input  logic              zero,
  input  logic              great,
  input  logic [15:0]       im1,
  input  logic [25:0]       im2,
  input  logic [3:0]        pc_op,
  input  logic [ADDR_W-1:0] j_reg,
  input  logic [ADDR_W-1:0] cop_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] rt_addr,
  output logic [ADDR_W-1:0] epc,
  output logic              bd
);

  localparam logic [3:0] PC_OP_NOP   = 4'd0;
  localparam logic [3:0] PC_OP_BZ    = 4'd1;
  localparam logic [3:0] PC_OP_BNZ   = 4'd2;
  localparam logic [3:0] PC_OP_BG    = 4'd3;
  localparam logic [3:0] PC_OP_BNG   = 4'd4;
  localparam logic [3:0] PC_OP_BGZ   = 4'd5;
  localparam logic [3:0] PC_OP_BNGNZ = 4'd6;
  localparam logic [3:0] PC_OP_J     = 4'd7;
  localparam logic [3:0] PC_OP_JR    = 4'd8;
  localparam logic [3:0] PC_OP_COP0  = 4'd9;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   pend_tgt_q, pend_tgt_d;
  logic                pend_valid_q, pend_valid_d;
  logic                in_slot_q, in_slot_d;
  logic [ADDR_W-1:0]   epc_q, epc_d;
  logic                bd_q, bd_d;

  logic [ADDR_W-1:0]   pc_plus4;
  logic [ADDR_W-1:0]   br_addr;
  logic [ADDR_W-1:0]   jmp_addr;
  logic [ADDR_W-1:0]   target;
  logic                taken;

  assign pc_plus4 = pc_q + ADDR_W'(4);
  assign br_addr  = pc_plus4 + {{(ADDR_W-18){im1[15]}}, im1, 2'b00};
  assign jmp_addr = {pc_q[ADDR_W-1:28], im2, 2'b00};

  always_comb begin
    taken  = 1'b0;
    target = br_addr;
    case (pc_op)
      PC_OP_BZ:    taken = zero;
      PC_OP_BNZ:   taken = !zero;
      PC_OP_BG:    taken = great;
      PC_OP_BNG:   taken = !great;
      PC_OP_BGZ:   taken = zero | great;
      PC_OP_BNGNZ: taken = !zero && !great;
      PC_OP_J: begin
        taken  = 1'b1;
        target = jmp_addr;
      end
      PC_OP_JR: begin
        taken  = 1'b1;
        target = j_reg;
      end
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_tgt_d   = pend_tgt_q;
    pend_valid_d = pend_valid_q;
    in_slot_d    = in_slot_q;
    epc_d        = epc_q;
    bd_d         = bd_q;
    if (pc_op == PC_OP_COP0) begin
      // Restart point of a slot instruction is its branch, one word back.
      epc_d        = in_slot_q ? (pc_q - ADDR_W'(4)) : pc_q;
      bd_d         = in_slot_q;
      pc_d         = cop_addr;
      pend_valid_d = 1'b0;
      in_slot_d    = 1'b0;
      state_d      = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (!stall) begin
            if (halt_req) begin
              state_d = ST_HALT;
            end else if (DELAY_SLOT) begin
              if (pend_valid_q) begin
                pc_d         = pend_tgt_q;
                pend_valid_d = 1'b0;
                in_slot_d    = 1'b0;
              end else if (taken) begin
                pc_d         = pc_plus4;
                pend_tgt_d   = target;
                pend_valid_d = 1'b1;
                in_slot_d    = 1'b1;
              end else begin
                pc_d = pc_plus4;
              end
            end else begin
              pc_d = taken ? target : pc_plus4;
            end
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_ADDR;
      pend_tgt_q   <= '0;
      pend_valid_q <= 1'b0;
      in_slot_q    <= 1'b0;
      epc_q        <= '0;
      bd_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_tgt_q   <= pend_tgt_d;
      pend_valid_q <= pend_valid_d;
      in_slot_q    <= in_slot_d;
      epc_q        <= epc_d;
      bd_q         <= bd_d;
    end
  end

  assign addr        = pc_q;
  assign fetch_valid = (state_q == ST_RUN);
  assign rt_addr     = pc_q + (DELAY_SLOT ? ADDR_W'(8) : ADDR_W'(4));
  assign epc         = epc_q;
  assign bd          = bd_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: three instances (immediate 32-bit, delay-slot 32-bit,
// immediate 64-bit) against a word-level reference model, plus directed cases.
module tb_pc_seq;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_BZ    = 4'd1;
  localparam logic [3:0] OP_BNZ   = 4'd2;
  localparam logic [3:0] OP_BG    = 4'd3;
  localparam logic [3:0] OP_BNG   = 4'd4;
  localparam logic [3:0] OP_BGZ   = 4'd5;
  localparam logic [3:0] OP_BNGNZ = 4'd6;
  localparam logic [3:0] OP_J     = 4'd7;
  localparam logic [3:0] OP_JR    = 4'd8;
  localparam logic [3:0] OP_COP0  = 4'd9;

  localparam logic [63:0] RA0 = 64'h100;
  localparam logic [63:0] RA1 = 64'h40;
  localparam logic [63:0] RA2 = 64'hFFFF_FFFF_FFFF_FFFC;

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        clk = 1'b0;
  logic        rest;
  logic        stall, halt_req, zero, great;
  logic [15:0] im1;
  logic [25:0] im2;
  logic [3:0]  pc_op;
  logic [63:0] j_reg, cop_addr;

  logic [31:0] a0, rt0, epc0, a1, rt1, epc1;
  logic [63:0] a2, rt2, epc2;
  logic        fv0, bd0, fv1, bd1, fv2, bd2;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_seq #(.ADDR_W(32), .RESET_ADDR(32'h100), .DELAY_SLOT(1'b0)) u0 (
    .clk(clk), .rest(rest), .stall(stall), .halt_req(halt_req), .zero(zero),
    .great(great), .im1(im1), .im2(im2), .pc_op(pc_op), .j_reg(j_reg[31:0]),
    .cop_addr(cop_addr[31:0]), .addr(a0), .fetch_valid(fv0), .rt_addr(rt0),
    .epc(epc0), .bd(bd0));

  pc_seq #(.ADDR_W(32), .RESET_ADDR(32'h40), .DELAY_SLOT(1'b1)) u1 (
    .clk(clk), .rest(rest), .stall(stall), .halt_req(halt_req), .zero(zero),
    .great(great), .im1(im1), .im2(im2), .pc_op(pc_op), .j_reg(j_reg[31:0]),
    .cop_addr(cop_addr[31:0]), .addr(a1), .fetch_valid(fv1), .rt_addr(rt1),
    .epc(epc1), .bd(bd1));

  pc_seq #(.ADDR_W(64), .RESET_ADDR(RA2), .DELAY_SLOT(1'b0)) u2 (
    .clk(clk), .rest(rest), .stall(stall), .halt_req(halt_req), .zero(zero),
    .great(great), .im1(im1), .im2(im2), .pc_op(pc_op), .j_reg(j_reg),
    .cop_addr(cop_addr), .addr(a2), .fetch_valid(fv2), .rt_addr(rt2),
    .epc(epc2), .bd(bd2));

  // Reference model: architectural view of one sequencer.
  typedef struct {
    logic [63:0] pc;
    int          mode;
    bit          pend;
    logic [63:0] pend_tgt;
    bit          slot;
    logic [63:0] epc;
    bit          bd;
  } mst_t;

  mst_t m0, m1, m2;

  function automatic logic [63:0] wmask(int aw);
    return (aw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << aw) - 64'd1);
  endfunction

  function automatic mst_t mreset(logic [63:0] ra);
    mst_t s;
    s.pc = ra; s.mode = M_BOOT; s.pend = 0; s.pend_tgt = 0;
    s.slot = 0; s.epc = 0; s.bd = 0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, int aw, bit ds);
    mst_t        n;
    logic [63:0] mk, seq, br, jmp, tgt;
    longint      off;
    bit          tk;
    n   = s;
    mk  = wmask(aw);
    if (pc_op == OP_COP0) begin
      n.epc  = (s.slot ? s.pc - 64'd4 : s.pc) & mk;
      n.bd   = s.slot;
      n.pc   = cop_addr & mk;
      n.pend = 0;
      n.slot = 0;
      n.mode = M_RUN;
      return n;
    end
    if (s.mode == M_BOOT) begin
      n.mode = M_RUN;
      return n;
    end
    if (s.mode != M_RUN || stall) return n;
    if (halt_req) begin
      n.mode = M_HALT;
      return n;
    end
    seq = (s.pc + 64'd4) & mk;
    off = longint'($signed(im1)) * 4;
    br  = (seq + 64'(off)) & mk;
    jmp = ((s.pc & mk) & ~64'h0FFF_FFFF) | (64'(im2) * 64'd4);
    tk  = 0;
    tgt = br;
    case (pc_op)
      OP_BZ:    tk = zero;
      OP_BNZ:   tk = !zero;
      OP_BG:    tk = great;
      OP_BNG:   tk = !great;
      OP_BGZ:   tk = zero || great;
      OP_BNGNZ: tk = !zero && !great;
      OP_J:     begin tk = 1; tgt = jmp; end
      OP_JR:    begin tk = 1; tgt = j_reg & mk; end
      default:  tk = 0;
    endcase
    if (ds && s.pend) begin
      n.pc = s.pend_tgt; n.pend = 0; n.slot = 0;
    end else if (tk && ds) begin
      n.pc = seq; n.pend_tgt = tgt; n.pend = 1; n.slot = 1;
    end else begin
      n.pc = tk ? tgt : seq;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rest) begin
    if (rest) begin
      m0 <= mreset(RA0);
      m1 <= mreset(RA1);
      m2 <= mreset(RA2);
    end else begin
      m0 <= mstep(m0, 32, 1'b0);
      m1 <= mstep(m1, 32, 1'b1);
      m2 <= mstep(m2, 64, 1'b0);
    end
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic mcheck();
    chk("m0 addr", 64'(a0), m0.pc);
    chk("m0 fetch_valid", 64'(fv0), 64'(m0.mode == M_RUN));
    chk("m0 rt_addr", 64'(rt0), (m0.pc + 64'd4) & wmask(32));
    chk("m0 epc", 64'(epc0), m0.epc);
    chk("m0 bd", 64'(bd0), 64'(m0.bd));
    chk("m1 addr", 64'(a1), m1.pc);
    chk("m1 fetch_valid", 64'(fv1), 64'(m1.mode == M_RUN));
    chk("m1 rt_addr", 64'(rt1), (m1.pc + 64'd8) & wmask(32));
    chk("m1 epc", 64'(epc1), m1.epc);
    chk("m1 bd", 64'(bd1), 64'(m1.bd));
    chk("m2 addr", a2, m2.pc);
    chk("m2 fetch_valid", 64'(fv2), 64'(m2.mode == M_RUN));
    chk("m2 rt_addr", rt2, m2.pc + 64'd4);
    chk("m2 epc", epc2, m2.epc);
    chk("m2 bd", 64'(bd2), 64'(m2.bd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mcheck();
  endtask

  task automatic idle_inputs();
    stall = 0; halt_req = 0; zero = 0; great = 0;
    im1 = 0; im2 = 0; pc_op = OP_NOP; j_reg = 0; cop_addr = 0;
  endtask

  task automatic redirect(logic [63:0] a);
    idle_inputs();
    pc_op = OP_COP0;
    cop_addr = a;
    tick();
    pc_op = OP_NOP;
  endtask

  typedef struct {
    string       name;
    logic [31:0] start;
    logic [3:0]  op;
    bit          z;
    bit          g;
    logic [15:0] i1;
    logic [25:0] i2;
    logic [31:0] jr;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(string nm, logic [31:0] st, logic [3:0] op, bit z, bit g,
                              logic [15:0] i1, logic [25:0] i2, logic [31:0] jr,
                              logic [31:0] ex);
    vec_t v;
    v.name = nm; v.start = st; v.op = op; v.z = z; v.g = g;
    v.i1 = i1; v.i2 = i2; v.jr = jr; v.exp = ex;
    return v;
  endfunction

  initial begin
    vec_t vt[$];
    vt.push_back(mk("bz_taken",    32'h200,      OP_BZ,    1, 0, 16'hFFFE, 0, 0, 32'h1FC));
    vt.push_back(mk("bz_not",      32'h200,      OP_BZ,    0, 0, 16'hFFFE, 0, 0, 32'h204));
    vt.push_back(mk("bnz_taken",   32'h200,      OP_BNZ,   0, 0, 16'h0010, 0, 0, 32'h244));
    vt.push_back(mk("bnz_not",     32'h200,      OP_BNZ,   1, 0, 16'h0010, 0, 0, 32'h204));
    vt.push_back(mk("bg_min_off",  32'h1000,     OP_BG,    0, 1, 16'h8000, 0, 0, 32'hFFFE_1004));
    vt.push_back(mk("bg_max_off",  32'h1000,     OP_BG,    0, 1, 16'h7FFF, 0, 0, 32'h0002_1000));
    vt.push_back(mk("bg_not",      32'h1000,     OP_BG,    0, 0, 16'h8000, 0, 0, 32'h1004));
    vt.push_back(mk("bng_taken",   32'h1000,     OP_BNG,   0, 0, 16'h0003, 0, 0, 32'h1010));
    vt.push_back(mk("bng_not",     32'h1000,     OP_BNG,   0, 1, 16'h0003, 0, 0, 32'h1004));
    vt.push_back(mk("bgz_zero",    32'h1000,     OP_BGZ,   1, 0, 16'h0001, 0, 0, 32'h1008));
    vt.push_back(mk("bgz_not",     32'h1000,     OP_BGZ,   0, 0, 16'h0001, 0, 0, 32'h1004));
    vt.push_back(mk("bngnz_taken", 32'h1000,     OP_BNGNZ, 0, 0, 16'h0002, 0, 0, 32'h100C));
    vt.push_back(mk("bngnz_not",   32'h1000,     OP_BNGNZ, 0, 1, 16'h0002, 0, 0, 32'h1004));
    vt.push_back(mk("j_high",      32'h3000_0010, OP_J,    0, 0, 0, 26'h3FF_FFFF, 0, 32'h3FFF_FFFC));
    vt.push_back(mk("jr",          32'h300,      OP_JR,    0, 0, 0, 0, 32'h500, 32'h500));
    vt.push_back(mk("nop_wrap",    32'hFFFF_FFFC, OP_NOP,  0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk("undef_op",    32'h800,      4'hF,     1, 1, 16'h0004, 0, 0, 32'h804));

    // Reset and boot sequence.
    idle_inputs();
    rest = 1;
    tick();
    tick();
    chk("reset addr", 64'(a0), 64'h100);
    chk("reset fetch_valid", 64'(fv0), 0);
    chk("reset epc", 64'(epc0), 0);
    chk("reset bd", 64'(bd0), 0);
    rest = 0;
    #1;
    chk("boot fetch_valid", 64'(fv0), 0);
    chk("boot addr", 64'(a0), 64'h100);
    tick();
    chk("run first fetch_valid", 64'(fv0), 1);
    chk("run first addr", 64'(a0), 64'h100);
    chk("rt_addr imm", 64'(rt0), 64'h104);
    chk("ds rt_addr at 0x40", 64'(rt1), 64'h48);
    chk("wide first addr", a2, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("run second addr", 64'(a0), 64'h104);
    chk("wide wrap addr", a2, 64'h0);
    tick();
    chk("run third addr", 64'(a0), 64'h108);

    // Table of single-decision cases on the immediate instance.
    foreach (vt[i]) begin
      redirect(64'(vt[i].start));
      chk({vt[i].name, " start"}, 64'(a0), 64'(vt[i].start));
      pc_op = vt[i].op; zero = vt[i].z; great = vt[i].g;
      im1 = vt[i].i1; im2 = vt[i].i2; j_reg = 64'(vt[i].jr);
      tick();
      chk(vt[i].name, 64'(a0), 64'(vt[i].exp));
    end

    // Delay slot: J takes effect after the slot; a branch in the slot is ignored.
    redirect(64'h40);
    chk("ds start addr", 64'(a1), 64'h40);
    chk("ds link addr", 64'(rt1), 64'h48);
    pc_op = OP_J; im2 = 26'h100;
    tick();
    chk("ds slot addr", 64'(a1), 64'h44);
    pc_op = OP_BNZ; zero = 0; im1 = 16'h0010;
    tick();
    chk("ds jump target", 64'(a1), 64'h400);
    idle_inputs();
    tick();
    chk("ds after jump", 64'(a1), 64'h404);

    // COP0 redirect while in the delay slot.
    redirect(64'h40);
    pc_op = OP_J; im2 = 26'h100;
    tick();
    chk("slot before cop0", 64'(a1), 64'h44);
    redirect(64'h8000_0180);
    chk("slot cop0 addr", 64'(a1), 64'h8000_0180);
    chk("slot cop0 epc", 64'(epc1), 64'h40);
    chk("slot cop0 bd", 64'(bd1), 1);
    tick();
    chk("slot pending cleared", 64'(a1), 64'h8000_0184);

    // Stall holds a JR decision until the pipeline accepts it.
    redirect(64'h300);
    pc_op = OP_JR; j_reg = 64'h500; stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall addr", 64'(a0), 64'h300);
      chk("stall fetch_valid", 64'(fv0), 1);
    end
    stall = 0;
    tick();
    chk("stall release addr", 64'(a0), 64'h500);

    // Halt and COP0 exit.
    redirect(64'h600);
    halt_req = 1;
    tick();
    halt_req = 0;
    chk("halt fetch_valid", 64'(fv0), 0);
    chk("halt addr", 64'(a0), 64'h600);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt frozen addr", 64'(a0), 64'h600);
      chk("halt frozen fetch_valid", 64'(fv0), 0);
    end
    redirect(64'h700);
    chk("halt exit fetch_valid", 64'(fv0), 1);
    chk("halt exit addr", 64'(a0), 64'h700);
    chk("halt exit epc", 64'(epc0), 64'h600);
    chk("halt exit bd", 64'(bd0), 0);

    // Asynchronous reset with a pending target outstanding.
    redirect(64'h1040);
    pc_op = OP_J; im2 = 26'h200;
    tick();
    idle_inputs();
    #2;
    rest = 1;
    #1;
    chk("midreset ds addr", 64'(a1), 64'h40);
    chk("midreset ds fetch_valid", 64'(fv1), 0);
    chk("midreset ds epc", 64'(epc1), 0);
    chk("midreset ds bd", 64'(bd1), 0);
    chk("midreset imm addr", 64'(a0), 64'h100);
    mcheck();
    rest = 0;
    tick();
    tick();
    chk("midreset no pending", 64'(a1), 64'h44);

    // Randomized run against the reference model.
    for (int c = 0; c < 600; c++) begin
      stall    = ($urandom_range(0, 3) == 0);
      halt_req = ($urandom_range(0, 29) == 0);
      zero     = $urandom_range(0, 1);
      great    = $urandom_range(0, 1);
      im1      = 16'($urandom);
      im2      = 26'($urandom);
      pc_op    = 4'($urandom_range(0, 15));
      j_reg    = {$urandom, $urandom};
      cop_addr = {$urandom, $urandom};
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
